// File: rtl/pll_div_capture_bank_pkg.sv
// Shared types and helpers for the clock-enable capture bank.
// Lock FSM states plus width and slice helpers used by top and channels.
package pll_div_capture_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKING,
    RUN
  } state_t;

  function automatic int lock_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/pll_div_channel.sv
// One capture channel: clock-enable divider, capture register, strobe.
// A divide field of zero behaves as divide-by-one.
module pll_div_channel #(
  parameter int WIDTH = 1,
  parameter int DIV_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;
  logic             tick;

  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = run && !cfg_load && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      q      <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= tick;
      if (tick && enable) q <= d;
      if (cfg_load || !run || tick) cnt <= '0;
      else cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pll_div_capture_bank.sv
// Multi-channel capture bank with lock-emulation FSM and per-channel
// clock-enable dividers, all on the single fabric clock.
module pll_div_capture_bank
  import pll_div_capture_bank_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int WIDTH       = 1,
  parameter int DIV_W       = 3,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pll_en,
  input  logic                      cfg_load,
  input  logic [CHANNELS*DIV_W-1:0] div_cfg,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [CHANNELS-1:0]       strobe_o,
  output logic                      locked_o
);

  localparam int LW = lock_w(LOCK_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [LW-1:0]             lock_cnt;
  logic [LW-1:0]             lock_nxt;
  logic [CHANNELS*DIV_W-1:0] div_q;
  logic                      run;

  // Dropping pll_en wins over every other transition.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    if (!pll_en) begin
      state_nxt = IDLE;
      lock_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = LOCKING;
          lock_nxt  = '0;
        end
        LOCKING: begin
          if (lock_cnt == LOCK_LAST) state_nxt = RUN;
          else lock_nxt = lock_cnt + LW'(1);
        end
        RUN: state_nxt = RUN;
        default: begin
          state_nxt = IDLE;
          lock_nxt  = '0;
        end
      endcase
    end
  end

  assign run = (state == RUN) && pll_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      locked_o <= 1'b0;
      div_q    <= {CHANNELS{DIV_W'(DEFAULT_DIV)}};
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_nxt;
      locked_o <= (state_nxt == RUN);
      if (cfg_load) div_q <= div_cfg;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pll_div_channel #(
      .WIDTH (WIDTH),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .cfg_load (cfg_load),
      .div      (div_q[slice_lo(c, DIV_W) +: DIV_W]),
      .d        (data_i[slice_lo(c, WIDTH) +: WIDTH]),
      .enable   (enable[c]),
      .q        (data_o[slice_lo(c, WIDTH) +: WIDTH]),
      .strobe   (strobe_o[c])
    );
  end

endmodule

// File: tb/tb_pll_div_capture_bank.sv
// Scoreboard bench for pll_div_capture_bank: a cycle model queues
// expected outputs per edge; directed checks cover the key scenarios.
module tb_pll_div_capture_bank;

  localparam int CH = 8;
  localparam int DW = 3;
  localparam int LC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            pll_en;
  logic            cfg_load;
  logic [CH*DW-1:0] div_cfg;
  logic [CH-1:0]   data_i;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   data_o;
  logic [CH-1:0]   strobe_o;
  logic            locked_o;

  pll_div_capture_bank #(
    .CHANNELS    (CH),
    .WIDTH       (1),
    .DIV_W       (DW),
    .DEFAULT_DIV (1),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_en   (pll_en),
    .cfg_load (cfg_load),
    .div_cfg  (div_cfg),
    .data_i   (data_i),
    .enable   (enable),
    .data_o   (data_o),
    .strobe_o (strobe_o),
    .locked_o (locked_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];

  int       m_state;
  int       m_lc;
  int       m_div[CH];
  int       m_cnt[CH];
  logic [CH-1:0] m_data;
  logic [CH-1:0] m_strobe;
  logic     m_locked;
  int       sc[4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int ns;
    int d;
    bit run;
    bit tick;
    if (rst) begin
      m_state = 0;
      m_lc = 0;
      m_data = '0;
      m_strobe = '0;
      m_locked = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_div[c] = 1;
        m_cnt[c] = 0;
      end
    end else begin
      run = (m_state == 2) && pll_en;
      for (int c = 0; c < CH; c++) begin
        d = (m_div[c] == 0) ? 1 : m_div[c];
        tick = run && !cfg_load && (m_cnt[c] == d - 1);
        m_strobe[c] = tick;
        if (tick && enable[c]) m_data[c] = data_i[c];
        if (cfg_load || !run || tick) m_cnt[c] = 0;
        else m_cnt[c] = m_cnt[c] + 1;
        if (cfg_load) m_div[c] = int'(div_cfg[c*DW +: DW]);
      end
      ns = m_state;
      if (!pll_en) begin
        ns = 0;
        m_lc = 0;
      end else if (m_state == 0) begin
        ns = 1;
        m_lc = 0;
      end else if (m_state == 1) begin
        if (m_lc == LC - 1) ns = 2;
        else m_lc = m_lc + 1;
      end
      m_state = ns;
      m_locked = (ns == 2);
    end
  endtask

  task automatic step();
    logic [16:0] e;
    model_edge();
    exp_q.push_back({m_locked, m_strobe, m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_data", 32'(data_o), 32'(e[7:0]));
    chk("sb_strobe", 32'(strobe_o), 32'(e[15:8]));
    chk("sb_locked", 32'(locked_o), 32'(e[16]));
  endtask

  task automatic load(input logic [CH*DW-1:0] cfg);
    div_cfg = cfg;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic relock();
    for (int i = 1; i <= LC + 1; i++) begin
      step();
      if (i == LC) chk("lock_early", 32'(locked_o), 32'd0);
      if (i == LC + 1) chk("lock_on", 32'(locked_o), 32'd1);
      chk("no_strobe", 32'(strobe_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_en = 1'b0;
    cfg_load = 1'b0;
    div_cfg = '0;
    data_i = '0;
    enable = '0;
    step();
    step();
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_strobe", 32'(strobe_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    rst = 1'b0;
    step();

    pll_en = 1'b1;
    relock();

    enable = 8'hFF;
    data_i = 8'hA5;
    load({CH{3'd1}});
    step();
    chk("all1_strobe", 32'(strobe_o), 32'hFF);
    chk("all1_data", 32'(data_o), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      data_i = 8'($urandom);
      step();
      chk("all1_every", 32'(strobe_o), 32'hFF);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    relock();
    enable = 8'h0F;
    load({3'd7, 3'd5, 3'd2, 3'd1, 3'd4, 3'd3, 3'd2, 3'd1});
    for (int c = 0; c < 4; c++) sc[c] = 0;
    for (int i = 0; i < 12; i++) begin
      data_i = 8'($urandom);
      step();
      for (int c = 0; c < 4; c++) sc[c] += int'(strobe_o[c]);
    end
    chk("per_d1", 32'(sc[0]), 32'd12);
    chk("per_d2", 32'(sc[1]), 32'd6);
    chk("per_d3", 32'(sc[2]), 32'd4);
    chk("per_d4", 32'(sc[3]), 32'd3);
    chk("hi_hold", 32'(data_o[7:4]), 32'd0);

    load({3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd0, 3'd1, 3'd1});
    for (int i = 1; i <= 4; i++) begin
      data_i = 8'($urandom);
      step();
      chk("d0_as_1", 32'(strobe_o[2]), 32'd1);
      chk("d4_phase", 32'(strobe_o[3]), (i == 4) ? 32'd1 : 32'd0);
    end
    step();
    step();
    load({3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd1});
    chk("reload_quiet", 32'(strobe_o[3]), 32'd0);
    step();
    chk("reload_1", 32'(strobe_o[3]), 32'd0);
    step();
    chk("reload_2", 32'(strobe_o[3]), 32'd1);

    enable = 8'hFF;
    data_i = 8'h3C;
    load({CH{3'd1}});
    step();
    step();
    chk("pre_drop", 32'(data_o), 32'h3C);
    pll_en = 1'b0;
    data_i = 8'h00;
    step();
    chk("drop_locked", 32'(locked_o), 32'd0);
    chk("drop_strobe", 32'(strobe_o), 32'd0);
    chk("drop_data", 32'(data_o), 32'h3C);
    step();
    chk("idle_data", 32'(data_o), 32'h3C);
    pll_en = 1'b1;
    relock();

    load({CH{3'd4}});
    step();
    step();
    rst = 1'b1;
    step();
    chk("rdiv_data", 32'(data_o), 32'd0);
    chk("rdiv_strobe", 32'(strobe_o), 32'd0);
    chk("rdiv_locked", 32'(locked_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("rlock_locked", 32'(locked_o), 32'd0);
    rst = 1'b0;
    relock();
    step();
    chk("dflt_div_a", 32'(strobe_o), 32'hFF);
    step();
    chk("dflt_div_b", 32'(strobe_o), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
